sample_tick_gen: RTL and testbench
==================================

Name: sample_tick_gen

Overview:
Programmable sample-rate divider that sits directly downstream of the speed-control stage. It consumes the 32-bit half-period count and produces a divided square clock plus a one-cycle sample strobe. The audio read/playback path uses these outputs to pace flash reads and audio samples. New periods are applied glitch-free at half-period boundaries. Out-of-range periods, including the wrap-around from repeated speed-down, are clamped.

Parameters:
MIN_HALF, 32'd2, smallest legal half-period in clk cycles
MAX_HALF, 32'd100000, largest legal half-period in clk cycles
DEFAULT_HALF, 32'd1227, active half-period loaded at reset

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  synchronous, active-high reset
half_cycle  input  32  requested half-period from speed control
enable  input  1  1 = run; 0 = freeze counter and outputs
restart  input  1  synchronous phase restart, one-cycle pulse or level
div_clk  output  1  divided square wave; period = 2*H clk cycles
sample_tick  output  1  one-cycle strobe on each 0->1 transition of div_clk
half_active  output  32  half-period H currently in force
clamped  output  1  registered; 1 = last sampled half_cycle was out of range

Behaviour:
- Reset and clocking: one clock domain; reset is synchronous and active-high. Priority: reset > restart > enable.
- Reset values: counter = 0, div_clk = 0, sample_tick = 0, half_active = DEFAULT_HALF, clamped = 0.
- Clamp function: clamp(x) = MIN_HALF if x < MIN_HALF; MAX_HALF if x > MAX_HALF; else x. Comparison is unsigned. Wrapped values near 2^32 therefore clamp to MAX_HALF.
- clamped flag: updated every cycle not in reset. It is set to 1 when half_cycle is out of range in the previous cycle, giving 1-cycle latency.
- Counter: 32-bit, runs 0..H-1. When enable=1 and counter == H-1 (terminal):
  - counter wraps to 0;
  - div_clk toggles;
  - sample_tick is 1 in the next cycle only if div_clk goes 0->1, registered on the same edge as div_clk;
  - half_active loads clamp(half_cycle), so a new H takes effect from the next half-period.
- When not at terminal with enable=1: counter increments; sample_tick = 0.
- enable=0: counter, div_clk and half_active hold; sample_tick = 0. Resuming continues from the held count with no extra tick.
- restart=1 (reset=0): counter = 0, div_clk = 0, sample_tick = 0, half_active = clamp(half_cycle), regardless of enable.
- Timing after reset release with enable=1 and fixed H:
  - div_clk rises at rising edges H, 3H, 5H, … and falls at edges 2H, 4H, …
  - sample_tick is high for exactly one cycle, coincident with div_clk rising.
- half_cycle changing mid-half-period: no effect until the next terminal count. No runt or stretched pulse; each half-period uses exactly one H.
- Simultaneous terminal count and restart: restart wins, and no tick is issued.
- H = MIN_HALF = 2: div_clk toggles every 2 cycles; sample_tick every 4 cycles.
- Counter width and comparison are both 32-bit unsigned. Counter never exceeds H-1 because H only changes at a wrap or restart.

Decomposition:
- Shared package speed_pkg: DEFAULT_HALF (1227), SPEED_STEP (5), HALF_W (32), and MIN_HALF/MAX_HALF defaults. The same constants are shared with the speed-control stage.
- One natural sub-module, half_cycle_clamp: purely combinational, with outputs value and out_of_range. It is instantiated once; its outputs feed the half_active load and the clamped flag.
- Counter, div_clk and strobe logic stay in the top module.

Test Plan:
- Reset, then half_cycle=1227, enable=1 → half_active=1227, div_clk first rises at edge 1227, sample_tick pulses every 2454 cycles, clamped=0.
- half_cycle changed 1227→1232 at counter=600 → current half-period still 1227 cycles; half_active=1232 after the next wrap; next full period = 2464.
- half_cycle=32'hFFFFFFFB (speed-down underflow) → clamped=1 one cycle later; half_active=100000 at next boundary. half_cycle=0 → half_active=2, tick every 4 cycles.
- enable low for 50 cycles at counter=700 → counter holds at 700, no ticks; resume → next toggle after 527 more enabled cycles.
- restart pulse at counter=900 with div_clk=1 → div_clk=0, counter=0, no tick; next rise 1227 cycles later.
- restart asserted on the same cycle as the terminal count → restart behaviour, no sample_tick; reset asserted mid-period → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/speed_pkg.sv
// speed_pkg: half-period constants and types shared by the speed-control and sample-rate stages.
package speed_pkg;
   localparam int unsigned HALF_W = 32;
   typedef logic [HALF_W-1:0] half_t;
   localparam half_t DEFAULT_HALF = 32'd1227;
   localparam half_t SPEED_STEP = 32'd5;
   localparam half_t MIN_HALF = 32'd2;
   localparam half_t MAX_HALF = 32'd100000;
endpackage

// File: rtl/half_cycle_clamp.sv
// half_cycle_clamp: limits a requested half-period to [MIN_HALF, MAX_HALF] and flags out-of-range requests.
module half_cycle_clamp
   import speed_pkg::*;
#(
   parameter half_t LO = speed_pkg::MIN_HALF,
   parameter half_t HI = speed_pkg::MAX_HALF
) (
   input  logic [HALF_W-1:0] half_cycle_i,
   output logic [HALF_W-1:0] value_o,
   output logic              out_of_range_o
);
   logic below, above;
   // Unsigned compare, so speed-down wrap-around near 2^32 lands on HI.
   assign below = half_cycle_i < LO;
   assign above = half_cycle_i > HI;
   assign value_o = below ? LO : above ? HI : half_cycle_i;
   assign out_of_range_o = below | above;
endmodule

// File: rtl/sample_tick_gen.sv
// sample_tick_gen: programmable half-period divider producing a square clock and a one-cycle sample strobe.
module sample_tick_gen
   import speed_pkg::*;
#(
   parameter half_t MIN_HALF = speed_pkg::MIN_HALF,
   parameter half_t MAX_HALF = speed_pkg::MAX_HALF,
   parameter half_t DEFAULT_HALF = speed_pkg::DEFAULT_HALF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [HALF_W-1:0] half_cycle,
   input  logic              enable,
   input  logic              restart,
   output logic              div_clk,
   output logic              sample_tick,
   output logic [HALF_W-1:0] half_active,
   output logic              clamped
);
   half_t cnt_q, cnt_d, half_q, half_d, clamp_val;
   logic div_q, div_d, tick_q, tick_d, clamped_q, clamped_d, oor, terminal;

   half_cycle_clamp #(.LO(MIN_HALF), .HI(MAX_HALF)) u_clamp (
      .half_cycle_i   (half_cycle),
      .value_o        (clamp_val),
      .out_of_range_o (oor)
   );

   // A new half-period is only accepted at a wrap or restart, so cnt_q never exceeds half_q-1.
   always_comb begin
      terminal = enable && (cnt_q == half_q - 1'b1);
      cnt_d = restart ? '0 : !enable ? cnt_q : terminal ? '0 : cnt_q + 1'b1;
      div_d = restart ? 1'b0 : terminal ? ~div_q : div_q;
      tick_d = !restart && terminal && !div_q;
      half_d = (restart || terminal) ? clamp_val : half_q;
      clamped_d = oor;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         div_q <= 1'b0;
         tick_q <= 1'b0;
         half_q <= DEFAULT_HALF;
         clamped_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         div_q <= div_d;
         tick_q <= tick_d;
         half_q <= half_d;
         clamped_q <= clamped_d;
      end
   end

   assign div_clk = div_q;
   assign sample_tick = tick_q;
   assign half_active = half_q;
   assign clamped = clamped_q;
endmodule

// File: tb/tb_sample_tick_gen.sv
// tb_sample_tick_gen: scoreboard bench; expected tick cycles are queued ahead and matched as ticks appear.
module tb_sample_tick_gen;
   logic clk = 1'b0, reset = 1'b1, enable = 1'b1, restart = 1'b0;
   logic [31:0] half_cycle = 32'd1227;
   logic div_clk, sample_tick, clamped;
   logic [31:0] half_active;
   int unsigned cyc = 0, n_cmp = 0, n_err = 0;
   int unsigned exp_q[$];
   int unsigned t, e, e2, e3, e4, r5;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sample_tick_gen dut (
      .clk         (clk),
      .reset       (reset),
      .half_cycle  (half_cycle),
      .enable      (enable),
      .restart     (restart),
      .div_clk     (div_clk),
      .sample_tick (sample_tick),
      .half_active (half_active),
      .clamped     (clamped)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   task automatic run_to(input int unsigned c);
      while (cyc < c) @(negedge clk);
   endtask

   always @(negedge clk)
      if (sample_tick !== 1'b0) begin
         if (exp_q.size() == 0) chk("spurious_tick", cyc, 0);
         else chk("tick_cycle", cyc, exp_q.pop_front());
      end

   initial begin
      run_to(3);
      chk("rst_div", div_clk, 0);
      chk("rst_tick", sample_tick, 0);
      chk("rst_half", half_active, 1227);
      chk("rst_clamped", clamped, 0);
      reset = 1'b0;
      t = 3;
      exp_q.push_back(t + 1227);
      exp_q.push_back(t + 3681);
      exp_q.push_back(t + 6140);
      exp_q.push_back(t + 8604);
      run_to(t + 1226); chk("div_pre_rise", div_clk, 0);
      run_to(t + 1227); chk("div_rise", div_clk, 1);
      chk("half_1227", half_active, 1227);
      chk("clamped_idle", clamped, 0);
      run_to(t + 2454); chk("div_fall", div_clk, 0);
      run_to(t + 4281); half_cycle = 32'd1232;
      run_to(t + 4907); chk("half_hold", half_active, 1227);
      chk("div_hold_high", div_clk, 1);
      run_to(t + 4908); chk("half_new", half_active, 1232);
      chk("div_fall_1227", div_clk, 0);
      run_to(t + 6140); chk("div_rise_1232", div_clk, 1);
      run_to(t + 8700); chk("clamped_before", clamped, 0);
      half_cycle = 32'hFFFF_FFFB;
      run_to(t + 8701); chk("clamped_after", clamped, 1);
      run_to(t + 9835); chk("half_pre_clamp", half_active, 1232);
      run_to(t + 9836); chk("half_max", half_active, 100000);
      chk("div_fall_1232", div_clk, 0);
      run_to(t + 9840); half_cycle = 32'd0; restart = 1'b1;
      run_to(t + 9841); restart = 1'b0;
      e = t + 9841;
      chk("half_min", half_active, 2);
      chk("div_restart_min", div_clk, 0);
      chk("clamped_zero", clamped, 1);
      exp_q.push_back(e + 2);
      exp_q.push_back(e + 6);
      exp_q.push_back(e + 10);
      exp_q.push_back(e + 14);
      run_to(e + 1); chk("min_div1", div_clk, 0);
      run_to(e + 2); chk("min_div2", div_clk, 1);
      run_to(e + 4); chk("min_div4", div_clk, 0);
      run_to(e + 15); half_cycle = 32'd1227; restart = 1'b1;
      run_to(e + 16); restart = 1'b0;
      e2 = e + 16;
      chk("half_back", half_active, 1227);
      chk("clamped_clear", clamped, 0);
      exp_q.push_back(e2 + 1277);
      run_to(e2 + 700); enable = 1'b0;
      run_to(e2 + 750); chk("freeze_div", div_clk, 0);
      chk("freeze_half", half_active, 1227);
      enable = 1'b1;
      run_to(e2 + 1276); chk("resume_pre", div_clk, 0);
      run_to(e2 + 1277); chk("resume_rise", div_clk, 1);
      run_to(e2 + 2177); chk("pre_restart_div", div_clk, 1);
      restart = 1'b1;
      run_to(e2 + 2178); restart = 1'b0;
      e3 = e2 + 2178;
      chk("restart_div", div_clk, 0);
      chk("restart_tick", sample_tick, 0);
      exp_q.push_back(e3 + 1227);
      run_to(e3 + 1227); chk("restart_rise", div_clk, 1);
      run_to(e3 + 3680); chk("pre_coinc_div", div_clk, 0);
      restart = 1'b1;
      run_to(e3 + 3681); restart = 1'b0;
      e4 = e3 + 3681;
      chk("coinc_div", div_clk, 0);
      chk("coinc_tick", sample_tick, 0);
      run_to(e4 + 499); half_cycle = 32'd1;
      run_to(e4 + 500); chk("clamped_low", clamped, 1);
      reset = 1'b1; half_cycle = 32'd40;
      run_to(e4 + 501);
      chk("mid_rst_div", div_clk, 0);
      chk("mid_rst_tick", sample_tick, 0);
      chk("mid_rst_half", half_active, 1227);
      chk("mid_rst_clamped", clamped, 0);
      run_to(e4 + 502); reset = 1'b0;
      r5 = e4 + 502;
      exp_q.push_back(r5 + 1227);
      exp_q.push_back(r5 + 1307);
      run_to(r5 + 1226); chk("post_rst_half", half_active, 1227);
      run_to(r5 + 1227); chk("half_40", half_active, 40);
      chk("post_rst_rise", div_clk, 1);
      run_to(r5 + 1267); chk("h40_fall", div_clk, 0);
      run_to(r5 + 1310); chk("pending_ticks", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
